// File: rtl/tdc_stop_emulator.sv
// Stop-word generator for the TDC encoder: turns a {coarse, phase} code into the
// raw 55-bit ring-oscillator snapshot plus the two coarse ripple counters.
module tdc_stop_emulator #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk40M,
  input  logic        rst_n,
  input  logic        sweep_en,
  input  logic [11:0] in_code,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [54:0] fine_raw_code,
  output logic [4:0]  counterA,
  output logic [4:0]  counterB,
  output logic        out_valid,
  output logic        code_err,
  output logic        sweep_done
);

  localparam int unsigned FINE_W   = 55;
  localparam int unsigned PHASE_W  = 7;
  localparam int unsigned COARSE_W = 5;
  localparam int unsigned CODE_W   = PHASE_W + COARSE_W;
  localparam int unsigned CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PHASE_W-1:0]  PHASE_SPLIT = 7'd55;
  localparam logic [PHASE_W-1:0]  PHASE_LAST  = 7'd109;
  localparam logic [COARSE_W-1:0] COARSE_LAST = 5'd31;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]          state, state_d;
  logic [CNT_W-1:0]    hold_cnt, hold_cnt_d;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   sweep_q, sweep_next;
  logic                last_q;
  logic                take_sweep, take_ext;
  logic                ext_bad, sweep_last;
  logic [FINE_W-1:0]   fine_d;
  logic [COARSE_W-1:0] counter_b_d;

  // in_ready is the only combinational output: it must track sweep_en in the same cycle
  always_comb begin
    in_ready = rst_n && (state == S_IDLE) && !sweep_en;
  end

  always_comb begin
    ext_bad    = in_code[PHASE_W-1:0] > PHASE_LAST;
    sweep_last = (sweep_q[CODE_W-1:PHASE_W] == COARSE_LAST) &&
                 (sweep_q[PHASE_W-1:0] == PHASE_LAST);
    if (sweep_q[PHASE_W-1:0] == PHASE_LAST) begin
      sweep_next = {sweep_q[CODE_W-1:PHASE_W] + 5'd1, 7'd0};
    end else begin
      sweep_next = {sweep_q[CODE_W-1:PHASE_W], sweep_q[PHASE_W-1:0] + 7'd1};
    end
  end

  // Thermometer decode: low half fills ones from bit 0, upper half clears from bit 0
  always_comb begin
    fine_d      = '0;
    counter_b_d = code_q[CODE_W-1:PHASE_W];
    if (code_q[PHASE_W-1:0] < PHASE_SPLIT) begin
      fine_d      = (FINE_W'(1) << code_q[PHASE_W-1:0]) - FINE_W'(1);
      counter_b_d = code_q[CODE_W-1:PHASE_W] - 5'd1;
    end else begin
      fine_d = ~((FINE_W'(1) << (code_q[PHASE_W-1:0] - PHASE_SPLIT)) - FINE_W'(1));
    end
  end

  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    take_sweep = 1'b0;
    take_ext   = 1'b0;
    case (state)
      S_IDLE: begin
        hold_cnt_d = '0;
        if (sweep_en) begin
          take_sweep = 1'b1;
          state_d    = S_LOAD;
        end else if (in_valid && in_ready) begin
          take_ext = 1'b1;
          if (!ext_bad) begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        hold_cnt_d = '0;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          hold_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      default: begin
        hold_cnt_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk40M) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  // Code capture, sweep source and registered raw outputs
  always_ff @(posedge clk40M) begin
    if (!rst_n) begin
      code_q        <= '0;
      last_q        <= 1'b0;
      sweep_q       <= '0;
      fine_raw_code <= '0;
      counterA      <= '0;
      counterB      <= '0;
      out_valid     <= 1'b0;
      code_err      <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      code_err   <= 1'b0;
      sweep_done <= 1'b0;
      if (take_sweep) begin
        code_q  <= sweep_q;
        last_q  <= sweep_last;
        sweep_q <= sweep_next;
      end else if (take_ext) begin
        code_err <= ext_bad;
        if (!ext_bad) begin
          code_q <= in_code;
          last_q <= 1'b0;
        end
      end
      if (state == S_LOAD) begin
        fine_raw_code <= fine_d;
        counterA      <= code_q[CODE_W-1:PHASE_W];
        counterB      <= counter_b_d;
        out_valid     <= 1'b1;
        sweep_done    <= last_q;
      end
    end
  end

endmodule
